// File: rtl/saddsub_pkg.sv
// Shared constants and range helpers for the pipelined signed add/sub.
package saddsub_pkg;

  localparam bit SAT_CLAMP = 1'b1;
  localparam bit SAT_WRAP  = 1'b0;

  function automatic logic [31:0] smax(input int w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  function automatic logic [31:0] smin(input int w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/saddsub_if.sv
// Operation/result bundle between a producer and saddsub_pipe.
interface saddsub_if #(
  parameter int WIDTH = 5
);
  logic             in_valid;
  logic             sub;
  logic             acc;
  logic             acc_clr;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             ovf;
  logic             ovf_sticky;

  modport master (
    output in_valid, sub, acc, acc_clr, a, b,
    input  out_valid, sum, ovf, ovf_sticky
  );

  modport slave (
    input  in_valid, sub, acc, acc_clr, a, b,
    output out_valid, sum, ovf, ovf_sticky
  );
endinterface

// File: rtl/sat_limit.sv
// Reduces a WIDTH+1 bit signed sum to WIDTH bits, clamping or wrapping.
module sat_limit
  import saddsub_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH:0]   raw,
  input  logic             sat,
  output logic [WIDTH-1:0] res,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(smax(WIDTH));
  localparam logic [WIDTH-1:0] MIN = WIDTH'(smin(WIDTH));

  // raw[WIDTH] is the true sign even when the low bits have overflowed
  always_comb begin
    ovf = raw[WIDTH] ^ raw[WIDTH-1];
    res = raw[WIDTH-1:0];
    if (ovf && (sat == SAT_CLAMP)) begin
      res = raw[WIDTH] ? MIN : MAX;
    end
  end

endmodule

// File: rtl/saddsub_pipe.sv
// Two-stage signed add/sub with saturate-or-wrap and an accumulator.
module saddsub_pipe
  import saddsub_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter bit SAT   = SAT_CLAMP
) (
  input logic       clk,
  input logic       rst,
  saddsub_if.slave  io
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH:0]   raw;
  logic [WIDTH-1:0] lim;
  logic             lim_ovf;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_res;
  logic             s1_ovf;

  always_comb begin
    x = io.a;
    y = io.b;
    if (io.acc) begin
      x = io.acc_clr ? '0 : acc_q;
      y = io.a;
    end
  end

  always_comb begin
    if (io.sub) raw = {x[WIDTH-1], x} - {y[WIDTH-1], y};
    else        raw = {x[WIDTH-1], x} + {y[WIDTH-1], y};
  end

  sat_limit #(.WIDTH(WIDTH)) u_lim (
    .raw (raw),
    .sat (SAT),
    .res (lim),
    .ovf (lim_ovf)
  );

  // Accumulator takes the limited result on the issuing edge, so the
  // next accumulate op sees it without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (io.in_valid && io.acc) begin
      acc_q <= lim;
    end else if (io.acc_clr) begin
      acc_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_res   <= '0;
      s1_ovf   <= 1'b0;
    end else begin
      s1_valid <= io.in_valid;
      if (io.in_valid) begin
        s1_res <= lim;
        s1_ovf <= lim_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      io.out_valid  <= 1'b0;
      io.sum        <= '0;
      io.ovf        <= 1'b0;
      io.ovf_sticky <= 1'b0;
    end else begin
      io.out_valid <= s1_valid;
      if (s1_valid) begin
        io.sum <= s1_res;
        io.ovf <= s1_ovf;
      end
      if (io.acc_clr) begin
        io.ovf_sticky <= 1'b0;
      end else if (s1_valid && s1_ovf) begin
        io.ovf_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: doc/saddsub_pipe.md
# saddsub_pipe

Parametrised, two-stage pipelined signed adder/subtractor with per-operation add/subtract select, selectable saturate-or-wrap overflow handling and an internal accumulator mode. Successor to the fixed 5-bit registered signed adder. Sits in the datapath wherever a registered two's-complement add/sub with overflow reporting is needed. Accepts one operation per clock under a valid qualifier, with fixed latency.

## Interface
- WIDTH, 5: operand/result width in bits, two's complement; legal 2..32.
- SAT, 1: 1 = clamp to the signed range on overflow; 0 = wrap (keep low WIDTH bits).
- clk  in  1  rising-edge clock; one clock for the whole block.
- rst  in  1  reset; synchronous and active-high.
- in_valid  in  1  operation present this cycle.
- sub  in  1  0 = add, 1 = subtract (x − y).
- acc  in  1  accumulate mode: x = accumulator, y = a; b ignored.
- acc_clr  in  1  zero the accumulator; with in_valid&acc it is applied before the operation.
- a  in  WIDTH  signed operand.
- b  in  WIDTH  signed operand (non-accumulate mode).
- out_valid  out  1  sum/ovf valid.
- sum  out  WIDTH  signed result.
- ovf  out  1  this result overflowed the signed range.
- ovf_sticky  out  1  OR of all ovf since the last rst or acc_clr.

## Operation
- Operand select: x = acc ? acc_q : a; y = acc ? a : b. If acc_clr is high, x = 0 in accumulate mode.
- Stage 1: raw = sext(x) ± sext(y), WIDTH+1 bits. ovf1 = raw[WIDTH] ≠ raw[WIDTH−1].
- Limit: if ovf1, SAT=1 gives MAX = 2^(WIDTH−1)−1 when raw is positive, or MIN = −2^(WIDTH−1) when negative. SAT=0 gives raw[WIDTH−1:0]. Otherwise the result is raw[WIDTH−1:0].
- Stage-1 register captures the limited result, ovf1 and in_valid.
- Accumulator acc_q:
  - Loads the limited result in the same edge when in_valid&acc.
  - Back-to-back accumulate ops see the previous result with no bubble.
  - acc_clr without in_valid&acc loads 0.
- Stage 2: registers onto sum/ovf/out_valid. When out_valid=0, sum and ovf hold their last values; consumers qualify with out_valid.
- ovf_sticky:
  - Set on any stage-2 capture with ovf=1.
  - Cleared by acc_clr, with the clear taking effect on the same edge.
  - A simultaneous overflow from an op issued in the acc_clr cycle sets it again two cycles later.
- No backpressure; an operation is accepted every cycle in_valid=1.
- sub with acc=0 and b=MIN: −MIN overflows and is handled by the normal limit rule.

## Timing
- Latency is 2. An operation sampled at edge k produces out_valid/sum/ovf after edge k+2. Throughput is 1 op per cycle.
- Reset:
  - rst high at an edge zeroes sum, ovf, ovf_sticky, out_valid, acc_q and both pipeline valids.
  - In-flight operations are discarded. out_valid is 0 after the reset edge and stays 0 for 2 cycles after the first post-reset in_valid.
  - rst has priority over all other inputs.
- Accumulator update is visible to an accumulate op issued on the very next edge (k+1).

## Structure
- Package saddsub_pkg holds:
  - functions smax(WIDTH) and smin(WIDTH);
  - constant SAT_CLAMP=1, SAT_WRAP=0.
- One natural sub-module, sat_limit: combinational, WIDTH-parameterised, maps raw WIDTH+1 bits plus SAT to a WIDTH-bit result plus ovf. It is instantiated once in stage 1.
- Everything else is in the top module: operand mux, accumulator, two pipeline registers.

## Test plan
All scenarios use WIDTH=5 and a 100 MHz clk.
- Positive overflow: a=01111, b=00001, sub=0, SAT=1 → sum=01111, ovf=1 at k+2. With SAT=0 → sum=10000, ovf=1.
- Negative overflow: a=10001 (−15), b=00011, sub=1, SAT=1 → sum=10000 (−16), ovf=1. With SAT=0 → sum=01110 (+14), ovf=1. Also a=00000, b=10000, sub=1 → sum=01111 (SAT=1) or 10000 (SAT=0), ovf=1.
- Streaming: in_valid=1 every cycle, a=0..9, b=1, sub=0 → out_valid continuous from the 3rd edge, sum=1..10 in order, ovf=0 throughout.
- Accumulate, SAT=1:
  - acc_clr with acc, a=5 → 5; then a=5, a=5 back-to-back → 10, 15.
  - next a=5 → 15, ovf=1, ovf_sticky=1.
  - then acc_clr & acc, a=−3 → −3, with ovf_sticky cleared.
- Reset mid-stream: rst asserted for one edge while 2 ops are in flight → out_valid=0 for the next 2 cycles, acc_q=0, ovf_sticky=0. The op issued right after reset appears at its k+2.
